// File: rtl/ddr_rd_pixel_unpacker.sv
// ddr_rd_pixel_unpacker: pops 128-bit words from the prefetch read FIFO and
// serialises them LSB-first into PIX_W-bit pixels, one per pixel request.
// It also counts pixels per line, resynchronises on vs_start and flags
// underflow. Define UNPACK_ERR_CNT_EN to add a saturating underflow counter
// on the err_cnt port.
module ddr_rd_pixel_unpacker #(
   parameter int unsigned DATA_W   = 128,
   parameter int unsigned PIX_W    = 16,
   parameter int unsigned H_ACTIVE = 1920
) (
   input  logic              rd_clk,
   input  logic              rd_rst,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic              fifo_vld,
   output logic              fifo_en,
   input  logic              vs_start,
   input  logic              pix_req,
   output logic [PIX_W-1:0]  pix_data,
   output logic              pix_vld,
   output logic              line_end,
   output logic              underflow
`ifdef UNPACK_ERR_CNT_EN
   ,
   output logic [15:0]       err_cnt
`endif
);

   localparam int unsigned PPW   = DATA_W / PIX_W;
   localparam int unsigned IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int unsigned LC_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PPW - 1);
   localparam logic [LC_W-1:0]  LC_LAST  = LC_W'(H_ACTIVE - 1);

   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_vld_q, hold_vld_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [LC_W-1:0]   line_q, line_d;
   logic [PIX_W-1:0]  pix_data_q, pix_data_d;
   logic              pix_vld_q, pix_vld_d;
   logic              line_end_q, line_end_d;
   logic              underflow_q, underflow_d;
   logic [PIX_W-1:0]  pix_sel;
   logic              load, serve, starve;

   // Pop only when the hold register is empty or its last pixel leaves this cycle.
   always_comb begin
      fifo_en = ~rd_rst & fifo_vld & ~vs_start &
                (~hold_vld_q | (pix_req & (idx_q == IDX_LAST)));
      load    = fifo_vld & fifo_en;
      serve   = pix_req & hold_vld_q & ~vs_start;
      starve  = pix_req & ~hold_vld_q & ~vs_start;
   end

   // Select the current pixel from the hold register, LSB lane first.
   always_comb begin
      pix_sel = '0;
      for (int unsigned k = 0; k < PPW; k++) begin
         if (idx_q == IDX_W'(k)) pix_sel = hold_q[k*PIX_W +: PIX_W];
      end
   end

   // Next-state: vs_start overrides serve/underflow/load and line counting.
   always_comb begin
      hold_d      = hold_q;
      hold_vld_d  = hold_vld_q;
      idx_d       = idx_q;
      line_d      = line_q;
      pix_data_d  = pix_data_q;
      pix_vld_d   = 1'b0;
      line_end_d  = 1'b0;
      underflow_d = 1'b0;
      if (vs_start) begin
         hold_vld_d = 1'b0;
         idx_d      = '0;
         line_d     = '0;
      end else begin
         if (serve) begin
            pix_data_d = pix_sel;
            pix_vld_d  = 1'b1;
            if (idx_q == IDX_LAST) begin
               idx_d      = '0;
               hold_vld_d = 1'b0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         if (starve) begin
            pix_data_d  = '0;
            underflow_d = 1'b1;
         end
         // A load in the same cycle as the last serve refills without a bubble.
         if (load) begin
            hold_d     = fifo_data;
            hold_vld_d = 1'b1;
            idx_d      = '0;
         end
         if (pix_req) begin
            if (line_q == LC_LAST) begin
               line_d     = '0;
               line_end_d = 1'b1;
            end else begin
               line_d = line_q + LC_W'(1);
            end
         end
      end
   end

   // State and registered outputs, asynchronously cleared by rd_rst.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         hold_q      <= '0;
         hold_vld_q  <= 1'b0;
         idx_q       <= '0;
         line_q      <= '0;
         pix_data_q  <= '0;
         pix_vld_q   <= 1'b0;
         line_end_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         hold_vld_q  <= hold_vld_d;
         idx_q       <= idx_d;
         line_q      <= line_d;
         pix_data_q  <= pix_data_d;
         pix_vld_q   <= pix_vld_d;
         line_end_q  <= line_end_d;
         underflow_q <= underflow_d;
      end
   end

   assign pix_data  = pix_data_q;
   assign pix_vld   = pix_vld_q;
   assign line_end  = line_end_q;
   assign underflow = underflow_q;

`ifdef UNPACK_ERR_CNT_EN
   logic [15:0] err_q, err_d;

   // Saturating underflow count; updates together with the underflow pulse.
   always_comb begin
      err_d = err_q;
      if (underflow_d && (err_q != '1)) err_d = err_q + 16'd1;
   end

   // Error counter register, cleared only by rd_rst.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) err_q <= '0;
      else        err_q <= err_d;
   end

   assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_ddr_rd_pixel_unpacker.sv
// Directed self-checking bench for ddr_rd_pixel_unpacker with a queue-based
// FIFO model. Checks err_cnt when UNPACK_ERR_CNT_EN is defined.
module tb_ddr_rd_pixel_unpacker;

   logic          rd_clk;
   logic          rd_rst;
   logic [127:0]  fifo_data;
   logic          fifo_vld;
   logic          fifo_en;
   logic          vs_start;
   logic          pix_req;
   logic [15:0]   pix_data;
   logic          pix_vld;
   logic          line_end;
   logic          underflow;
`ifdef UNPACK_ERR_CNT_EN
   logic [15:0]   err_cnt;
`endif

   int            checks = 0;
   int            errors = 0;
   logic [127:0]  fq[$];
   logic          fifo_on;
   logic          last_en;
   int            pops;

   ddr_rd_pixel_unpacker #(.DATA_W(128), .PIX_W(16), .H_ACTIVE(1920)) dut (
      .rd_clk    (rd_clk),
      .rd_rst    (rd_rst),
      .fifo_data (fifo_data),
      .fifo_vld  (fifo_vld),
      .fifo_en   (fifo_en),
      .vs_start  (vs_start),
      .pix_req   (pix_req),
      .pix_data  (pix_data),
      .pix_vld   (pix_vld),
      .line_end  (line_end),
      .underflow (underflow)
`ifdef UNPACK_ERR_CNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   function automatic logic [127:0] make_word(input int base);
      logic [127:0] w;
      for (int k = 0; k < 8; k++) w[k*16 +: 16] = 16'(base + k);
      return w;
   endfunction

   // One clock cycle: present inputs, record fifo_en, model the pop, sample after the edge.
   task automatic cycle(input logic req, input logic vs);
      logic popped;
      logic [127:0] tmp;
      pix_req   = req;
      vs_start  = vs;
      fifo_vld  = fifo_on && (fq.size() > 0);
      fifo_data = fifo_vld ? fq[0] : '0;
      #1;
      last_en = fifo_en;
      popped  = fifo_vld & fifo_en;
      @(posedge rd_clk);
      #1;
      if (popped) begin
         tmp = fq.pop_front();
         pops++;
      end
      pix_req  = 1'b0;
      vs_start = 1'b0;
   endtask

   task automatic do_reset();
      rd_rst   = 1'b1;
      pix_req  = 1'b0;
      vs_start = 1'b0;
      fifo_vld = 1'b0;
      fifo_on  = 1'b0;
      fifo_data = '0;
      fq.delete();
      pops = 0;
      repeat (2) @(posedge rd_clk);
      #1;
      rd_rst = 1'b0;
   endtask

   task automatic test_reset();
      rd_rst   = 1'b1;
      fifo_vld = 1'b1;
      fifo_data = make_word(0);
      pix_req  = 1'b1;
      vs_start = 1'b0;
      @(posedge rd_clk);
      #1;
      checks++;
      if (pix_data !== 16'h0) begin errors++; $display("FAIL reset_pix_data: got %h expected 0000", pix_data); end
      checks++;
      if (pix_vld !== 1'b0) begin errors++; $display("FAIL reset_pix_vld: got %b expected 0", pix_vld); end
      checks++;
      if (line_end !== 1'b0 || underflow !== 1'b0) begin
         errors++; $display("FAIL reset_pulses: got line_end=%b underflow=%b expected 0 0", line_end, underflow);
      end
      checks++;
      if (fifo_en !== 1'b0) begin errors++; $display("FAIL reset_fifo_en: got %b expected 0", fifo_en); end
`ifdef UNPACK_ERR_CNT_EN
      checks++;
      if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
`endif
   endtask

   task automatic test_stream();
      do_reset();
      fq.push_back(make_word(0));
      fq.push_back(make_word(8));
      fifo_on = 1'b1;
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, 1'b0);
         checks++;
         if (pix_data !== 16'(i) || pix_vld !== 1'b1) begin
            errors++; $display("FAIL stream_pix[%0d]: got %h vld=%b expected %h vld=1", i, pix_data, pix_vld, 16'(i));
         end
         checks++;
         if (underflow !== 1'b0) begin errors++; $display("FAIL stream_underflow[%0d]: got %b expected 0", i, underflow); end
      end
      checks++;
      if (pops !== 2) begin errors++; $display("FAIL stream_pops: got %0d expected 2", pops); end
   endtask

   task automatic test_underflow();
      do_reset();
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0);
         checks++;
         if (underflow !== 1'b1 || pix_vld !== 1'b0 || pix_data !== 16'h0) begin
            errors++; $display("FAIL uflow[%0d]: got uf=%b vld=%b data=%h expected 1 0 0000", i, underflow, pix_vld, pix_data);
         end
      end
`ifdef UNPACK_ERR_CNT_EN
      checks++;
      if (err_cnt !== 16'd3) begin errors++; $display("FAIL uflow_err_cnt: got %0d expected 3", err_cnt); end
`endif
      cycle(1'b0, 1'b0);
      checks++;
      if (underflow !== 1'b0) begin errors++; $display("FAIL uflow_idle: got %b expected 0", underflow); end
      fq.push_back(make_word(0));
      fifo_on = 1'b1;
      cycle(1'b1, 1'b0);
      checks++;
      if (last_en !== 1'b1 || underflow !== 1'b1 || pix_vld !== 1'b0) begin
         errors++; $display("FAIL uflow_load: got en=%b uf=%b vld=%b expected 1 1 0", last_en, underflow, pix_vld);
      end
      cycle(1'b1, 1'b0);
      checks++;
      if (pix_data !== 16'h0000 || pix_vld !== 1'b1 || underflow !== 1'b0) begin
         errors++; $display("FAIL uflow_recover0: got %h vld=%b uf=%b expected 0000 1 0", pix_data, pix_vld, underflow);
      end
      cycle(1'b1, 1'b0);
      checks++;
      if (pix_data !== 16'h0001 || pix_vld !== 1'b1) begin
         errors++; $display("FAIL uflow_recover1: got %h vld=%b expected 0001 1", pix_data, pix_vld);
      end
`ifdef UNPACK_ERR_CNT_EN
      checks++;
      if (err_cnt !== 16'd4) begin errors++; $display("FAIL uflow_err_cnt2: got %0d expected 4", err_cnt); end
`endif
   endtask

   task automatic test_vs_start();
      do_reset();
      fq.push_back(make_word(0));
      fq.push_back(make_word(8));
      fifo_on = 1'b1;
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0);
         checks++;
         if (pix_data !== 16'(i)) begin errors++; $display("FAIL vs_pre[%0d]: got %h expected %h", i, pix_data, 16'(i)); end
      end
      cycle(1'b1, 1'b1);
      checks++;
      if (last_en !== 1'b0 || pops !== 1) begin
         errors++; $display("FAIL vs_no_pop: got en=%b pops=%0d expected 0 1", last_en, pops);
      end
      checks++;
      if (pix_vld !== 1'b0 || underflow !== 1'b0 || line_end !== 1'b0) begin
         errors++; $display("FAIL vs_outputs: got vld=%b uf=%b le=%b expected 0 0 0", pix_vld, underflow, line_end);
      end
      cycle(1'b0, 1'b0);
      checks++;
      if (last_en !== 1'b1) begin errors++; $display("FAIL vs_refill: got en=%b expected 1", last_en); end
      cycle(1'b1, 1'b0);
      checks++;
      if (pix_data !== 16'h0008 || pix_vld !== 1'b1) begin
         errors++; $display("FAIL vs_next_word: got %h vld=%b expected 0008 1", pix_data, pix_vld);
      end
   endtask

   task automatic test_line_end();
      int le_count;
      le_count = 0;
      do_reset();
      for (int w = 0; w < 481; w++) fq.push_back(make_word(w * 8));
      for (int i = 0; i < 3840; i++) begin
         fifo_on = (i >= 4);
         cycle(1'b1, 1'b0);
         if (line_end === 1'b1) le_count++;
         checks++;
         if (line_end !== ((i == 1919) || (i == 3839))) begin
            errors++; $display("FAIL line_end[%0d]: got %b expected %b", i, line_end, (i == 1919) || (i == 3839));
         end
         checks++;
         if (underflow !== (i < 5)) begin
            errors++; $display("FAIL line_uf[%0d]: got %b expected %b", i, underflow, (i < 5));
         end
         if (i >= 5) begin
            checks++;
            if (pix_data !== 16'(i - 5) || pix_vld !== 1'b1) begin
               errors++; $display("FAIL line_pix[%0d]: got %h vld=%b expected %h 1", i, pix_data, pix_vld, 16'(i - 5));
            end
         end
      end
      checks++;
      if (le_count !== 2) begin errors++; $display("FAIL line_end_count: got %0d expected 2", le_count); end
      cycle(1'b0, 1'b0);
      checks++;
      if (line_end !== 1'b0) begin errors++; $display("FAIL line_end_idle: got %b expected 0", line_end); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fq.push_back(make_word(0));
      fq.push_back(make_word(8));
      fifo_on = 1'b1;
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
      checks++;
      if (pix_data !== 16'h0004 || pix_vld !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre: got %h vld=%b expected 0004 1", pix_data, pix_vld);
      end
      fifo_vld  = 1'b1;
      fifo_data = fq[0];
      rd_rst    = 1'b1;
      #1;
      checks++;
      if (pix_data !== 16'h0 || pix_vld !== 1'b0 || fifo_en !== 1'b0) begin
         errors++; $display("FAIL rstmid_async: got data=%h vld=%b en=%b expected 0000 0 0", pix_data, pix_vld, fifo_en);
      end
      @(posedge rd_clk);
      #1;
      checks++;
      if (fifo_en !== 1'b0) begin errors++; $display("FAIL rstmid_hold_en: got %b expected 0", fifo_en); end
      rd_rst = 1'b0;
      cycle(1'b0, 1'b0);
      checks++;
      if (last_en !== 1'b1 || pops !== 2) begin
         errors++; $display("FAIL rstmid_pop: got en=%b pops=%0d expected 1 2", last_en, pops);
      end
      cycle(1'b1, 1'b0);
      checks++;
      if (pix_data !== 16'h0008 || pix_vld !== 1'b1) begin
         errors++; $display("FAIL rstmid_first: got %h vld=%b expected 0008 1", pix_data, pix_vld);
      end
   endtask

   task automatic test_sparse();
      do_reset();
      fq.push_back(make_word(0));
      fq.push_back(make_word(8));
      fq.push_back(make_word(16));
      fifo_on = 1'b1;
      cycle(1'b0, 1'b0);
      for (int j = 0; j < 16; j++) begin
         cycle(1'b1, 1'b0);
         checks++;
         if (last_en !== ((j % 8) == 7)) begin
            errors++; $display("FAIL sparse_req_en[%0d]: got %b expected %b", j, last_en, (j % 8) == 7);
         end
         checks++;
         if (pix_data !== 16'(j) || pix_vld !== 1'b1) begin
            errors++; $display("FAIL sparse_pix[%0d]: got %h vld=%b expected %h 1", j, pix_data, pix_vld, 16'(j));
         end
         checks++;
         if (pops !== 1 + (j + 1) / 8) begin
            errors++; $display("FAIL sparse_pops[%0d]: got %0d expected %0d", j, pops, 1 + (j + 1) / 8);
         end
         for (int g = 0; g < 2; g++) begin
            cycle(1'b0, 1'b0);
            checks++;
            if (last_en !== 1'b0 || pix_vld !== 1'b0) begin
               errors++; $display("FAIL sparse_idle[%0d.%0d]: got en=%b vld=%b expected 0 0", j, g, last_en, pix_vld);
            end
         end
      end
   endtask

   initial begin
      rd_rst    = 1'b1;
      pix_req   = 1'b0;
      vs_start  = 1'b0;
      fifo_vld  = 1'b0;
      fifo_data = '0;
      fifo_on   = 1'b0;
      last_en   = 1'b0;
      pops      = 0;
      test_reset();
      test_stream();
      test_underflow();
      test_vs_start();
      test_line_end();
      test_reset_mid();
      test_sparse();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
